// File: rtl/kadai09_6_1.sv
// kadai09_6_1 -- unsigned array multiplier with a registered product, z = a * b.
//
// The core is built from AND-gate partial products that are summed row by row.
// Each row is a ripple chain that starts with a half adder and continues with
// full adders. The core uses no '*' operator.
//
// Optional macro KADAI09_6_1_PIPE_EN adds a register stage after the first adder
// row. This makes latency 2 cycles. Throughput stays one pair per cycle.
// Without the macro the product appears one cycle after the operands.

// Half adder: first column of every adder row.
module kadai09_6_1_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = x ^ y;
    assign co = x & y;
endmodule

// Full adder: remaining columns of every adder row.
module kadai09_6_1_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// One adder row: adds a WIDTH-bit partial product to the WIDTH accumulator bits
// aligned with it. The carry ripples column to column. The carry out becomes the
// next accumulator bit above this row.
module kadai09_6_1_row #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] pp,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // Each column has its own scalar carry, so the ripple chain is a chain of
    // distinct nets rather than one vector that feeds back into itself.
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
        logic c;
        if (j == 0) begin : g_ha
            kadai09_6_1_ha u_ha (
                .x  (acc[0]),
                .y  (pp[0]),
                .s  (sum[0]),
                .co (c)
            );
        end else begin : g_fa
            kadai09_6_1_fa u_fa (
                .x  (acc[j]),
                .y  (pp[j]),
                .ci (g_col[j-1].c),
                .s  (sum[j]),
                .co (c)
            );
        end
    end

    assign cout = g_col[WIDTH-1].c;
endmodule

module kadai09_6_1 #(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   z,
    output logic                 out_valid
);
    localparam int PW = 2 * WIDTH;
    // K is the index of the last row computed in front of the optional stage
    // register. It is row 1, the first adder row. A 1-bit multiplier has no
    // adder row, so K is 0 in that case.
    localparam int K  = (WIDTH > 1) ? 1 : 0;

`ifdef KADAI09_6_1_PIPE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    logic [PW-1:0]     acc0;
    logic [PW-1:0]     front_sum;
    logic [PW-1:0]     mid_sum;
    logic [PW-1:0]     final_sum;
    logic [WIDTH-1:0]  mid_a;
    logic [WIDTH-1:0]  mid_b;
    logic [STAGES:1]   vld_q;
    logic [STAGES:0]   vld_pipe;

    // Row 0 is the partial product a & b[0] by itself. It needs no adders.
    assign acc0 = {{WIDTH{1'b0}}, a & {WIDTH{b[0]}}};

    // First adder row. It sits in front of the optional stage register.
    if (K == 1) begin : g_front
        logic [WIDTH-1:0] s;
        logic             co;
        kadai09_6_1_row #(.WIDTH(WIDTH)) u_row (
            .acc  (acc0[1 +: WIDTH]),
            .pp   (a & {WIDTH{b[1]}}),
            .sum  (s),
            .cout (co)
        );
        assign front_sum = ({{(WIDTH-1){1'b0}}, co, s} << 1)
                         | {{(PW-1){1'b0}}, acc0[0]};
    end else begin : g_front_none
        assign front_sum = acc0;
    end

`ifdef KADAI09_6_1_PIPE_EN
    // Stage-1 register. It holds the running sum after row 1, plus the operands
    // that the remaining rows still need. It loads only on a valid pair, so
    // idle-cycle garbage on a/b never enters the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            mid_sum <= '0;
            mid_a   <= '0;
            mid_b   <= '0;
        end else if (in_valid) begin
            mid_sum <= front_sum;
            mid_a   <= a;
            mid_b   <= b;
        end
    end
`else
    assign mid_sum = front_sum;
    assign mid_a   = a;
    assign mid_b   = b;
`endif

    // Remaining adder rows K+1 .. WIDTH-1. Row i adds (a & b[i]) at bit offset
    // i. Bits below i pass through untouched. Bits above i+WIDTH are still zero.
    for (genvar i = K + 1; i < WIDTH; i++) begin : g_row
        localparam logic [PW-1:0] LOW = ~({PW{1'b1}} << i);
        logic [PW-1:0]    prev;
        logic [PW-1:0]    sum;
        logic [WIDTH-1:0] s;
        logic             co;

        if (i == K + 1) begin : g_first
            assign prev = mid_sum;
        end else begin : g_next
            assign prev = g_row[i-1].sum;
        end

        kadai09_6_1_row #(.WIDTH(WIDTH)) u_row (
            .acc  (prev[i +: WIDTH]),
            .pp   (mid_a & {WIDTH{mid_b[i]}}),
            .sum  (s),
            .cout (co)
        );

        assign sum = ({{(WIDTH-1){1'b0}}, co, s} << i) | (prev & LOW);
    end

    if (WIDTH - 1 >= K + 1) begin : g_final_rows
        assign final_sum = g_row[WIDTH-1].sum;
    end else begin : g_final_mid
        assign final_sum = mid_sum;
    end

    // Some operand and row-0 bits are consumed by only some configurations.
    // Reducing them here keeps every configuration free of dangling signals.
    logic unused_bits;
    assign unused_bits = ^{acc0, mid_a, mid_b};

    // Valid shift register. It advances every cycle, and reset clears every stage.
    assign vld_pipe = {vld_q, in_valid};

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_pipe[STAGES-1:0];
    end

    // Output register. It loads a new product when the pair reaching the last
    // stage was valid. Otherwise it holds the previous product.
    always_ff @(posedge clk) begin
        if (rst)                       z <= '0;
        else if (vld_pipe[STAGES-1])   z <= final_sum;
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_kadai09_6_1.sv
// Self-checking bench for kadai09_6_1.
// Default build: WIDTH=2 and latency 1.
// With KADAI09_6_1_PIPE_EN defined: WIDTH=4 and latency 2.
// A per-cycle delay-line model is compared on every clock. Literal expectations
// pin the model to hand-computed results.
module tb_kadai09_6_1;
`ifdef KADAI09_6_1_PIPE_EN
    localparam int W   = 4;
    localparam int LAT = 2;
`else
    localparam int W   = 2;
    localparam int LAT = 1;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2*W-1:0]   z;
    logic             out_valid;

    int checks = 0;
    int errors = 0;

    kadai09_6_1 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .z         (z),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference model: a LAT-deep delay line of (valid, product).
    // The product comes from plain integer multiplication. The output holds its
    // last product when an invalid slot emerges. Reset empties the line and zeroes z.
    logic             pv [LAT];
    logic [2*W-1:0]   pz [LAT];
    logic [2*W-1:0]   mz;
    logic             mv;

    initial begin
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pz[i] = '0;
        end
        mz = '0;
        mv = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
                mz = '0;
                mv = 1'b0;
            end else begin
                for (int i = LAT - 1; i > 0; i--) begin
                    pv[i] = pv[i-1];
                    pz[i] = pz[i-1];
                end
                pv[0] = in_valid;
                if (in_valid) pz[0] = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                mv = pv[LAT-1];
                if (pv[LAT-1]) mz = pz[LAT-1];
            end
            #1;
            chk("model_z", 64'(z), 64'(mz));
            chk("model_out_valid", 64'(out_valid), 64'(mv));
        end
    end

    // One clock: inputs change 2 time units after an edge, so they are stable
    // at the next edge. The task returns just after that edge has taken effect.
    task automatic cyc(input logic r, input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb);
        rst      = r;
        in_valid = v;
        a        = aa;
        b        = bb;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; a = '0; b = '0;

        // Reset with a valid 3*3 pending; reset wins.
        cyc(1'b1, 1'b1, W'(3), W'(3));
        chk("reset_z_0", 64'(z), 64'd0);
        chk("reset_ov_0", 64'(out_valid), 64'd0);
        cyc(1'b1, 1'b1, W'(3), W'(3));
        chk("reset_z_1", 64'(z), 64'd0);
        chk("reset_ov_1", 64'(out_valid), 64'd0);
        cyc(1'b0, 1'b1, W'(3), W'(3));
`ifndef KADAI09_6_1_PIPE_EN
        chk("release_3x3", 64'(z), 64'd9);
        chk("release_ov", 64'(out_valid), 64'd1);
`endif

        // Sweep: b held, a swept, one pair per cycle.
        for (int bb = 0; bb < 4; bb++) begin
            for (int aa = 0; aa < 4; aa++) begin
                cyc(1'b0, 1'b1, W'(aa), W'(bb));
`ifndef KADAI09_6_1_PIPE_EN
                chk("sweep_ov", 64'(out_valid), 64'd1);
                if (aa == 2 && bb == 1) chk("sweep_2x1", 64'(z), 64'd2);
                if (aa == 3 && bb == 2) chk("sweep_3x2", 64'(z), 64'd6);
                if (aa == 2 && bb == 2) chk("sweep_2x2", 64'(z), 64'd4);
                if (aa == 3 && bb == 3) chk("sweep_3x3", 64'(z), 64'd9);
`endif
            end
        end

        // Hold: z keeps its value while in_valid is low, even with garbage operands.
        cyc(1'b0, 1'b1, W'(3), W'(2));
        for (int k = 0; k < LAT - 1; k++) cyc(1'b0, 1'b0, W'(1), W'(1));
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, W'(1), W'(1));
            chk("hold_z", 64'(z), 64'd6);
            chk("hold_ov", 64'(out_valid), 64'd0);
        end
        cyc(1'b0, 1'b0, 'x, 'x);
        chk("hold_x_z", 64'(z), 64'd6);

        // Zero boundaries.
        cyc(1'b0, 1'b1, W'(0), W'(3));
`ifndef KADAI09_6_1_PIPE_EN
        chk("zero_a", 64'(z), 64'd0);
`endif
        cyc(1'b0, 1'b1, W'(3), W'(0));
`ifndef KADAI09_6_1_PIPE_EN
        chk("zero_b", 64'(z), 64'd0);
`endif

        // Reset mid-stream discards the pending 3*3; next pair 1*3 is computed.
        cyc(1'b0, 1'b1, W'(3), W'(2));
        cyc(1'b1, 1'b1, W'(3), W'(3));
        chk("midrst_z", 64'(z), 64'd0);
        chk("midrst_ov", 64'(out_valid), 64'd0);
        cyc(1'b0, 1'b1, W'(1), W'(3));
`ifndef KADAI09_6_1_PIPE_EN
        chk("after_rst_1x3", 64'(z), 64'd3);
        chk("after_rst_ov", 64'(out_valid), 64'd1);
        cyc(1'b0, 1'b1, W'(3), W'(3));
        chk("max_3x3", 64'(z), 64'd9);
`else
        cyc(1'b0, 1'b0, W'(0), W'(0));
        chk("after_rst_1x3", 64'(z), 64'd3);
        chk("after_rst_ov", 64'(out_valid), 64'd1);

        // Pipelined back-to-back: 15*15 then 7*9.
        cyc(1'b0, 1'b1, W'(15), W'(15));
        chk("pipe_first_ov", 64'(out_valid), 64'd0);
        cyc(1'b0, 1'b1, W'(7), W'(9));
        chk("pipe_15x15", 64'(z), 64'd225);
        chk("pipe_15x15_ov", 64'(out_valid), 64'd1);
        cyc(1'b0, 1'b0, W'(0), W'(0));
        chk("pipe_7x9", 64'(z), 64'd63);
        chk("pipe_7x9_ov", 64'(out_valid), 64'd1);
        cyc(1'b0, 1'b0, W'(0), W'(0));
        chk("pipe_drain_z", 64'(z), 64'd63);
        chk("pipe_drain_ov", 64'(out_valid), 64'd0);
`endif

        cyc(1'b0, 1'b0, W'(0), W'(0));
        cyc(1'b0, 1'b0, W'(0), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
